pipe_stall_ctrl: RTL and testbench

//  Central stall sequencer for the 5-stage pipeline. Merges stall requests from ID (load-use),
//  EX (multi-cycle divide) and MEM (data SRAM wait) into the per-stage stall bus. Owns the divide

---
 rtl/pipe_stall_ctrl_pkg.sv | 23 ++
 rtl/pipe_stall_ctrl_if.sv | 26 ++
 rtl/pipe_stall_ctrl_inst_hold_buf.sv | 43 ++++
 rtl/pipe_stall_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus encodings and sequencer state codes for the pipeline stall controller.
package pipe_stall_ctrl_pkg;

  typedef logic [5:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; each value bubbles the stage above the top 1.
  localparam StallBus STALL_NONE = 6'b000000;
  localparam StallBus STALL_ID   = 6'b000111;
  localparam StallBus STALL_EX   = 6'b001111;
  localparam StallBus STALL_MEM  = 6'b011111;

  localparam int STALL_ID_BIT = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall request / stall bus bundle between the pipeline stages and the stall sequencer.
interface pipe_stall_ctrl_if #(
  parameter int INST_W = 32
);
  import pipe_stall_ctrl_pkg::*;

  logic              stallreq_id;
  logic              div_start;
  logic              mem_req;
  logic              mem_ack;
  logic [INST_W-1:0] inst_sram_rdata;
  StallBus           stall;
  logic              div_done;
  logic [INST_W-1:0] id_inst;

  modport master (
    output stallreq_id, div_start, mem_req, mem_ack, inst_sram_rdata,
    input  stall, div_done, id_inst
  );

  modport slave (
    input  stallreq_id, div_start, mem_req, mem_ack, inst_sram_rdata,
    output stall, div_done, id_inst
  );

endinterface

// File: rtl/pipe_stall_ctrl_inst_hold_buf.sv
// Keeps the instruction word that arrived when ID first stalled, so ID sees it again on release.
module inst_hold_buf
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hold_en,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic [INST_W-1:0] id_inst
);

  logic              hold_valid_q, hold_valid_d;
  logic [INST_W-1:0] inst_hold_q, inst_hold_d;

  // Only the first stalled cycle is captured; later SRAM words belong to the next fetch.
  always_comb begin
    hold_valid_d = hold_valid_q;
    inst_hold_d  = inst_hold_q;
    if (hold_en == Stop) begin
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        inst_hold_d  = inst_sram_rdata;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_q <= 1'b0;
      inst_hold_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      inst_hold_q  <= inst_hold_d;
    end
  end

  assign id_inst = hold_valid_q ? inst_hold_q : inst_sram_rdata;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer: merges ID/EX/MEM stall requests, times the divider, owns the ID hold buffer.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33,
  parameter int INST_W     = 32
) (
  input logic              clk,
  input logic              resetn,
  pipe_stall_ctrl_if.slave bus
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  state_e            state_q;
  logic [CNT_W-1:0]  div_cnt_q;
  logic              div_pend_q;
  logic              mem_stall;
  logic              div_active;
  logic              div_last;
  StallBus           stall_w;
  logic [INST_W-1:0] id_inst_w;

  assign mem_stall = bus.mem_req & ~bus.mem_ack;

  // The cycle that leaves MEM_WAIT with a divide pending is a divide cycle in its own right.
  assign div_active = (state_q == DIV_WAIT) || ((state_q == MEM_WAIT) && div_pend_q);
  assign div_last   = div_active && !mem_stall && (div_cnt_q == '0);

  always_comb begin
    stall_w = STALL_NONE;
    if (mem_stall)
      stall_w = STALL_MEM;
    else if (bus.div_start || div_active)
      stall_w = STALL_EX;
    else if (bus.stallreq_id)
      stall_w = STALL_ID;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RUN;
      div_cnt_q  <= '0;
      div_pend_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEM_WAIT;
            // A divide issued under a MEM stall does not get its first cycle counted.
            if (bus.div_start) begin
              div_pend_q <= 1'b1;
              div_cnt_q  <= CNT_W'(DIV_CYCLES - 1);
            end
          end else if (bus.div_start) begin
            state_q   <= DIV_WAIT;
            div_cnt_q <= CNT_W'(DIV_CYCLES - 2);
          end
        end
        DIV_WAIT: begin
          if (mem_stall) begin
            state_q    <= MEM_WAIT;
            div_pend_q <= 1'b1;
          end else if (div_cnt_q == '0) begin
            state_q <= RUN;
          end else begin
            div_cnt_q <= div_cnt_q - CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            if (div_pend_q) begin
              div_pend_q <= 1'b0;
              if (div_cnt_q == '0) begin
                state_q <= RUN;
              end else begin
                state_q   <= DIV_WAIT;
                div_cnt_q <= div_cnt_q - CNT_W'(1);
              end
            end else if (bus.div_start) begin
              state_q   <= DIV_WAIT;
              div_cnt_q <= CNT_W'(DIV_CYCLES - 2);
            end else begin
              state_q <= RUN;
            end
          end
        end
        default: begin
          state_q    <= RUN;
          div_pend_q <= 1'b0;
        end
      endcase
    end
  end

  inst_hold_buf #(
    .INST_W (INST_W)
  ) u_hold (
    .clk             (clk),
    .resetn          (resetn),
    .hold_en         (stall_w[STALL_ID_BIT]),
    .inst_sram_rdata (bus.inst_sram_rdata),
    .id_inst         (id_inst_w)
  );

  assign bus.stall    = stall_w;
  assign bus.div_done = div_last;
  assign bus.id_inst  = id_inst_w;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed vector bench for the pipeline stall sequencer.
module tb_pipe_stall_ctrl;
  localparam int DIV_CYCLES = 33;
  localparam int INST_W     = 32;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  pipe_stall_ctrl_if #(.INST_W(INST_W)) bus ();

  pipe_stall_ctrl #(
    .DIV_CYCLES (DIV_CYCLES),
    .INST_W     (INST_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sreq;
    logic        dstart;
    logic        mreq;
    logic        mack;
    logic [31:0] rdata;
    logic [5:0]  exp_stall;
    logic        exp_done;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic sreq, input logic dstart, input logic mreq, input logic mack,
                       input logic [31:0] rdata);
    bus.stallreq_id     = sreq;
    bus.div_start       = dstart;
    bus.mem_req         = mreq;
    bus.mem_ack         = mack;
    bus.inst_sram_rdata = rdata;
  endtask

  // Full divide window starting next cycle; optional MEM stall burst and one ID request inside.
  task automatic div_window(input int mem_start, input int mem_len, input int id_at);
    int last;
    int dones;
    logic [5:0] es;
    logic m_r, m_a;
    last  = DIV_CYCLES - 1 + mem_len;
    dones = 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      m_r = 1'b0; m_a = 1'b0;
      if (k >= mem_start && k < mem_start + mem_len) m_r = 1'b1;
      else if (mem_len > 0 && k == mem_start + mem_len) begin m_r = 1'b1; m_a = 1'b1; end
      drive(k == id_at, k == 0, m_r, m_a, 32'h5000_0000 + k);
      @(negedge clk);
      es = (m_r && !m_a) ? 6'b011111 : 6'b001111;
      chk($sformatf("div_stall_k%0d", k), {26'd0, bus.stall}, {26'd0, es});
      chk($sformatf("div_done_k%0d", k), {31'd0, bus.div_done}, {31'd0, k == last});
      if (bus.div_done) dones++;
    end
    chk("div_done_count", dones, 1);
  endtask

  task automatic idle_check(input string nm, input logic [31:0] rdata);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, rdata);
    @(negedge clk);
    chk({nm, "_stall"}, {26'd0, bus.stall}, 32'd0);
    chk({nm, "_done"}, {31'd0, bus.div_done}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    #3;
    chk("rst_stall", {26'd0, bus.stall}, 32'd0);
    chk("rst_done", {31'd0, bus.div_done}, 32'd0);
    chk("rst_inst", bus.id_inst, 32'h1234_5678);
    chk("rst_hold_valid", {31'd0, dut.u_hold.hold_valid_q}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Idle, load-use hold, MEM handshake, same-cycle req+ack, ID request absorbed by MEM stall.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 6'b000000, 1'b0, 32'h1111_1111};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h2222_2222, 6'b000000, 1'b0, 32'h2222_2222};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h8C43_0004, 6'b000111, 1'b0, 32'h8C43_0004};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 6'b000000, 1'b0, 32'h8C43_0004};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 6'b000000, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0001, 6'b011111, 1'b0, 32'hA000_0001};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0002, 6'b011111, 1'b0, 32'hA000_0001};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0003, 6'b011111, 1'b0, 32'hA000_0001};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0004, 6'b011111, 1'b0, 32'hA000_0001};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0005, 6'b000000, 1'b0, 32'hA000_0001};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0000, 6'b000000, 1'b0, 32'hB000_0000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hC000_0000, 6'b011111, 1'b0, 32'hC000_0000};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hC000_0001, 6'b000111, 1'b0, 32'hC000_0000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hC000_0002, 6'b000000, 1'b0, 32'hC000_0000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hC000_0003, 6'b000000, 1'b0, 32'hC000_0003};

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].sreq, vecs[i].dstart, vecs[i].mreq, vecs[i].mack, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), {26'd0, bus.stall}, {26'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_done", i), {31'd0, bus.div_done}, {31'd0, vecs[i].exp_done});
      chk($sformatf("vec%0d_inst", i), bus.id_inst, vecs[i].exp_inst);
    end

    // Longer idle stretch: ID must track the SRAM word directly.
    for (int i = 0; i < 10; i++) begin
      idle_check($sformatf("idle%0d", i), 32'h0300_0000 + i);
      chk($sformatf("idle%0d_inst", i), bus.id_inst, 32'h0300_0000 + i);
    end

    // Plain divide with an ID request absorbed at t+3, then back-to-back divide.
    div_window(1000, 0, 3);
    div_window(1000, 0, -1);
    idle_check("after_b2b", 32'h0);

    // MEM wait of 3 cycles starting at t+5 pushes done to t+35.
    div_window(5, 3, -1);
    idle_check("after_memdiv", 32'h0);

    // Asynchronous reset in the middle of a divide.
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      drive(1'b0, k == 0, 1'b0, 1'b0, 32'h7000_0000 + k);
      @(negedge clk);
      chk($sformatf("rdiv_stall_k%0d", k), {26'd0, bus.stall}, 32'h0000_000F);
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("amid_stall", {26'd0, bus.stall}, 32'd0);
    chk("amid_done", {31'd0, bus.div_done}, 32'd0);
    chk("amid_hold_valid", {31'd0, dut.u_hold.hold_valid_q}, 32'd0);
    chk("amid_inst", bus.id_inst, 32'h7000_000A);
    for (int i = 0; i < 3; i++) idle_check($sformatf("inrst%0d", i), 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) idle_check($sformatf("postrst%0d", i), 32'h0);
    div_window(1000, 0, -1);
    idle_check("final", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
